median3_row: RTL



---
 rtl/median3_row.sv | 119 +++++++++++
 1 files changed

// File: rtl/median3_row.sv
// Horizontal 3-tap median stage between a show-ahead pixel FIFO and a downstream FIFO.
// Emits one filtered pixel per input pixel, replicating the edge pixel at both line borders.
//
// state | meaning
// FIRST | waiting for pixel 0 of a line; primes both window taps, no output
// RUN   | each accepted pixel completes the window for the previous column
// LAST  | no read; emits the final column from the replicated right edge
module median3_row #(
   parameter int size   = 8,
   parameter int LINE_W = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [size-1:0] in_data,
   input  logic            in_valid,
   output logic            in_rd,
   output logic [size-1:0] out_data,
   output logic            out_wr,
   input  logic            out_full,
   output logic            out_last
);

   localparam int CW = $clog2(LINE_W);

   localparam logic [1:0] FIRST = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] LAST  = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   col_q, col_d;
   logic [size-1:0] w_prev_q, w_prev_d;
   logic [size-1:0] w_cur_q, w_cur_d;
   logic            pend_q, pend_d;
   logic [size-1:0] pend_data_q, pend_data_d;
   logic            pend_last_q, pend_last_d;
   logic            free;

   function automatic logic [size-1:0] med3(input logic [size-1:0] a,
                                            input logic [size-1:0] b,
                                            input logic [size-1:0] c);
      logic [size-1:0] lo, hi, m;
      lo = (a < b) ? a : b;
      hi = (a < b) ? b : a;
      m  = (hi < c) ? hi : c;
      return (lo > m) ? lo : m;
   endfunction

   assign out_wr   = pend_q & ~out_full & ~rst;
   assign out_data = pend_data_q;
   assign out_last = pend_last_q;
   assign free     = ~pend_q | out_wr;
   assign in_rd    = in_valid & free & ~rst & (state_q != LAST);

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      w_prev_d    = w_prev_q;
      w_cur_d     = w_cur_q;
      pend_d      = pend_q & ~out_wr;
      pend_data_d = pend_data_q;
      pend_last_d = pend_last_q;
      case (state_q)
         FIRST: begin
            if (in_rd) begin
               w_prev_d = in_data;
               w_cur_d  = in_data;
               col_d    = CW'(1);
               state_d  = RUN;
            end
         end
         RUN: begin
            if (in_rd) begin
               pend_d      = 1'b1;
               pend_data_d = med3(w_prev_q, w_cur_q, in_data);
               pend_last_d = 1'b0;
               w_prev_d    = w_cur_q;
               w_cur_d     = in_data;
               if (col_q == CW'(LINE_W - 1)) state_d = LAST;
               else                          col_d   = col_q + 1'b1;
            end
         end
         LAST: begin
            // med(p[W-2], p[W-1], p[W-1]) is always p[W-1]
            if (free) begin
               pend_d      = 1'b1;
               pend_data_d = w_cur_q;
               pend_last_d = 1'b1;
               col_d       = '0;
               state_d     = FIRST;
            end
         end
         default: begin
            state_d = FIRST;
            col_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= FIRST;
         col_q       <= '0;
         w_prev_q    <= '0;
         w_cur_q     <= '0;
         pend_q      <= 1'b0;
         pend_data_q <= '0;
         pend_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         w_prev_q    <= w_prev_d;
         w_cur_q     <= w_cur_d;
         pend_q      <= pend_d;
         pend_data_q <= pend_data_d;
         pend_last_q <= pend_last_d;
      end
   end

endmodule
